// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline control unit for the 5-stage Y86-64 core.
//
// Generates the stall/bubble controls for the F/D/E/M/W pipeline registers
// and the condition-code write enable. It also sequences three things:
//   - a bubble flush after reset,
//   - draining the pipe once an exception reaches memory,
//   - halting once the excepting instruction reaches write-back.
//
// Optional feature: define PIPE_PERF_CNT_EN to build the saturating
// performance counters. Without it the counter ports are tied to zero and
// no counter flops exist.
//
// Parameters
//   FLUSH_CYCLES  bubble cycles after reset release (1..15)
//   CNT_W         width of each performance counter
//
// Ports
//   clk, reset                   core clock, synchronous active-high reset
//   D_icode, d_srcA, d_srcB      decode-stage instruction and source registers
//   E_icode, E_dstM, e_Cnd       execute-stage instruction, load dest, branch cond
//   M_icode, m_stat, W_stat      memory/write-back instruction and status
//   F_stall, D_stall, W_stall    hold the corresponding pipeline register
//   D_bubble, E_bubble, M_bubble load a nop into the corresponding register
//   set_cc                       condition-code update enable
//   cpu_stat                     registered processor status
//   halted                       high while stopped
//   cyc_cnt, stall_cnt, mispred_cnt, ret_cnt   performance counters
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic [2:0]       cpu_stat,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SADR = 3'd2;
  localparam logic [2:0] SINS = 3'd3;
  localparam logic [2:0] SHLT = 3'd4;

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] RNONE    = 4'hF;

  // The flush counter counts down to zero inclusive, so it is loaded with
  // one less than the number of bubble cycles wanted.
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] flush_cnt, flush_cnt_nxt;
  logic [2:0] stat_nxt;

  logic lu, ret, mp, m_exc, w_exc;

  function automatic logic is_exc(input logic [2:0] s);
    return (s == SADR) || (s == SINS) || (s == SHLT);
  endfunction

  // Hazard detection
  always_comb begin
    lu = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != RNONE) &&
         ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    ret   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    mp    = (E_icode == I_JXX) && !e_Cnd;
    m_exc = is_exc(m_stat);
    w_exc = is_exc(W_stat);
  end

  // Next state and control outputs
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    stat_nxt      = cpu_stat;
    F_stall       = 1'b0;
    D_stall       = 1'b0;
    D_bubble      = 1'b0;
    E_bubble      = 1'b0;
    M_bubble      = 1'b0;
    W_stall       = 1'b0;
    set_cc        = 1'b0;
    halted        = 1'b0;
    if (reset) begin
      // Outputs already look like a flush while reset is held.
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else begin
      unique case (state)
        ST_FLUSH: begin
          D_bubble = 1'b1;
          E_bubble = 1'b1;
          M_bubble = 1'b1;
          if (flush_cnt == 4'd0) state_nxt = ST_RUN;
          else                   flush_cnt_nxt = flush_cnt - 4'd1;
        end
        ST_RUN, ST_DRAIN: begin
          F_stall  = lu | ret;
          D_stall  = lu;
          // A load-use stall must hold D, so it overrides the ret bubble.
          D_bubble = mp | (ret & !lu);
          E_bubble = mp | lu;
          M_bubble = m_exc | w_exc;
          W_stall  = w_exc;
          set_cc   = (E_icode == I_OPQ) & !m_exc & !w_exc;
          // The write-back exception takes priority over entering drain.
          if (w_exc) begin
            state_nxt = ST_STOP;
            stat_nxt  = W_stat;
          end else if ((state == ST_RUN) && m_exc) begin
            state_nxt = ST_DRAIN;
          end
        end
        ST_STOP: begin
          F_stall  = 1'b1;
          D_stall  = 1'b1;
          W_stall  = 1'b1;
          E_bubble = 1'b1;
          M_bubble = 1'b1;
          halted   = 1'b1;
        end
        default: state_nxt = ST_FLUSH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_FLUSH;
      flush_cnt <= FLUSH_INIT;
      cpu_stat  <= SAOK;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      cpu_stat  <= stat_nxt;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic cnt_active;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic              en);
    if (en && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  // Counters only advance while instructions are flowing.
  assign cnt_active = !reset && ((state == ST_RUN) || (state == ST_DRAIN));

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt     <= '0;
      stall_cnt   <= '0;
      mispred_cnt <= '0;
      ret_cnt     <= '0;
    end else if (cnt_active) begin
      cyc_cnt     <= sat_inc(cyc_cnt, 1'b1);
      stall_cnt   <= sat_inc(stall_cnt, D_stall);
      mispred_cnt <= sat_inc(mispred_cnt, mp);
      ret_cnt     <= sat_inc(ret_cnt, ret & !lu);
    end
  end
`else
  assign cyc_cnt     = '0;
  assign stall_cnt   = '0;
  assign mispred_cnt = '0;
  assign ret_cnt     = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios followed by randomized
// episodes, all checked cycle by cycle against a behavioural model.
module tb_pipe_ctrl;

  localparam int FC  = 4;
  localparam int CW  = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic          e_Cnd;
  logic [2:0]    m_stat, W_stat;
  logic          F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
  logic          set_cc, halted;
  logic [2:0]    cpu_stat;
  logic [CW-1:0] cyc_cnt, stall_cnt, mispred_cnt, ret_cnt;

  pipe_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .set_cc(set_cc), .cpu_stat(cpu_stat), .halted(halted),
    .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt),
    .mispred_cnt(mispred_cnt), .ret_cnt(ret_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: how many flush cycles remain, whether the core has
  // stopped, the latched status and the event tallies.
  int       m_flush_left;
  bit       m_stopped;
  int       m_stat_q;
  int       m_cyc, m_stall, m_mp, m_ret;

  function automatic bit exc(input logic [2:0] s);
    return s >= 3'd2 && s <= 3'd4;
  endfunction

  function automatic int bump(input int v, input bit en);
    if (en && v < MAXC) return v + 1;
    return v;
  endfunction

  task automatic model_reset();
    m_flush_left = FC;
    m_stopped    = 0;
    m_stat_q     = 1;
    m_cyc = 0; m_stall = 0; m_mp = 0; m_ret = 0;
  endtask

  // One clock cycle: inputs are already applied. Check outputs at the
  // falling edge, then advance the model across the rising edge.
  task automatic tick(input string tag);
    bit lu, rt, mp, me, we;
    logic [7:0] exp_v, got_v;
    int ec, es, em, er;
    lu = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
         (E_dstM == d_srcA || E_dstM == d_srcB);
    rt = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
    mp = (E_icode == 4'h7) && !e_Cnd;
    me = exc(m_stat);
    we = exc(W_stat);
    @(negedge clk);
    // order: F_stall D_stall D_bubble E_bubble M_bubble W_stall set_cc halted
    if (reset || m_flush_left > 0) exp_v = 8'b0011_1000;
    else if (m_stopped)            exp_v = 8'b1101_1101;
    else exp_v = {lu | rt, lu, mp | (rt & !lu), mp | lu, me | we, we,
                  (E_icode == 4'h6) & !me & !we, 1'b0};
    got_v = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted};
    chk({tag, ".ctrl"}, 32'(got_v), 32'(exp_v));
    chk({tag, ".stat"}, 32'(cpu_stat), 32'(m_stat_q));
`ifdef PIPE_PERF_CNT_EN
    ec = m_cyc; es = m_stall; em = m_mp; er = m_ret;
`else
    ec = 0; es = 0; em = 0; er = 0;
`endif
    chk({tag, ".cyc"},     32'(cyc_cnt),     32'(ec));
    chk({tag, ".stall"},   32'(stall_cnt),   32'(es));
    chk({tag, ".mispred"}, 32'(mispred_cnt), 32'(em));
    chk({tag, ".ret"},     32'(ret_cnt),     32'(er));
    @(posedge clk);
    if (reset) model_reset();
    else if (m_flush_left > 0) m_flush_left--;
    else if (!m_stopped) begin
      m_cyc   = bump(m_cyc, 1);
      m_stall = bump(m_stall, lu);
      m_mp    = bump(m_mp, mp);
      m_ret   = bump(m_ret, rt & !lu);
      if (we) begin
        m_stopped = 1;
        m_stat_q  = int'(W_stat);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
    e_Cnd = 1'b1; m_stat = 3'd1; W_stat = 3'd1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < n; i++) tick("rst");
    reset = 1'b0;
    for (int i = 0; i < FC; i++) tick("flush");
  endtask

  function automatic logic [3:0] rnd_icode();
    logic [3:0] tbl [7] = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB};
    return tbl[$urandom_range(0, 6)];
  endfunction

  function automatic logic [3:0] rnd_reg();
    int r = $urandom_range(0, 5);
    return (r == 5) ? 4'hF : 4'(r);
  endfunction

  function automatic logic [2:0] rnd_stat(input int rate);
    if ($urandom_range(0, rate) == 0) return 3'($urandom_range(2, 4));
    return 3'd1;
  endfunction

  initial begin
    // Bring the DUT into a known state before the model starts tracking.
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    model_reset();

    // Reset held a second cycle, then the flush and an idle pipe.
    tick("rst2");
    reset = 1'b0;
    for (int i = 0; i < FC + 3; i++) tick("t1");

    // Load-use hazard, then the same with no memory destination.
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; tick("t2_lu");
    E_dstM = 4'hF; d_srcA = 4'hF;                 tick("t2_none");
    idle_inputs();

    // Mispredicted and correctly predicted jump.
    E_icode = 4'h7; e_Cnd = 1'b0; tick("t3_mp");
    e_Cnd = 1'b1;                 tick("t3_ok");
    idle_inputs();

    // Return alone, then combined with a load-use.
    D_icode = 4'h9; tick("t4_ret");
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; tick("t4_ret_lu");
    idle_inputs();

    // Exception drain and halt, held, then reset out of STOP.
    E_icode = 4'h6; m_stat = 3'd2; tick("t5_drain");
    m_stat = 3'd1; W_stat = 3'd2;  tick("t5_stop");
    idle_inputs();
    for (int i = 0; i < 10; i++) tick("t5_hold");
    do_reset(1);
    tick("t5_run");

    // Twenty load-use cycles push the stall counter to saturation.
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    for (int i = 0; i < 20; i++) tick("t6_sat");
    idle_inputs();

    // Randomized episodes with occasional mid-run resets.
    for (int ep = 0; ep < 8; ep++) begin
      do_reset(1 + (ep % 2));
      for (int c = 0; c < 70; c++) begin
        D_icode = rnd_icode(); E_icode = rnd_icode(); M_icode = rnd_icode();
        d_srcA = rnd_reg(); d_srcB = rnd_reg(); E_dstM = rnd_reg();
        e_Cnd  = 1'($urandom_range(0, 1));
        m_stat = rnd_stat(25 + 10 * ep);
        W_stat = rnd_stat(40 + 10 * ep);
        reset  = ($urandom_range(0, 60) == 0);
        tick("rand");
      end
      reset = 1'b0;
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  // Safety net in case the stimulus ever stops advancing.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

endmodule
